// File: rtl/usr_shift_ctrl_if.sv
// Command handshake bundle between a command source and usr_shift_ctrl.
// The optional rotate bit is present only when USR_SHIFT_CTRL_ROTATE_EN is defined.
interface usr_shift_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [LEN_W-1:0] cmd_len;
    logic [WIDTH-1:0] cmd_data;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
    logic             cmd_rot;
`endif

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_len,
        output cmd_data,
`ifdef USR_SHIFT_CTRL_ROTATE_EN
        output cmd_rot,
`endif
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_len,
        input  cmd_data,
`ifdef USR_SHIFT_CTRL_ROTATE_EN
        input  cmd_rot,
`endif
        output cmd_ready
    );
endinterface

// File: rtl/usr_shift_ctrl.sv
// Command sequencer for a 4-bit universal shift register: load, then shift
// len times, streaming the departing bit and pulsing done with the final value.
// Optional feature macro: USR_SHIFT_CTRL_ROTATE_EN (rotate fill from departing bit).
module usr_shift_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    usr_shift_ctrl_if.slave  cmd,
    input  logic             ser_in,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_fb,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] p_in,
    output logic             s_r_in,
    output logic             s_l_in,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [1:0]       state,     state_nxt;
    logic             dir_q,     dir_nxt;
    logic [LEN_W-1:0] len_q,     len_nxt;
    logic [LEN_W-1:0] count_q,   count_nxt;
    logic [WIDTH-1:0] data_q,    data_nxt;
    logic             aborted_q, aborted_nxt;
    logic             rot_q,     rot_nxt;
    logic             departing;
    logic             fill;
    logic             rot_in;

`ifdef USR_SHIFT_CTRL_ROTATE_EN
    assign rot_in = cmd.cmd_rot;
`else
    assign rot_in = 1'b0;
`endif

    // Bit leaving the register this cycle and the bit entering the vacated end.
    assign departing = dir_q ? q_fb[WIDTH-1] : q_fb[0];
    assign fill      = rot_q ? departing : ser_in;

    // State and command-capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            dir_q     <= 1'b0;
            len_q     <= '0;
            count_q   <= '0;
            data_q    <= '0;
            aborted_q <= 1'b0;
            rot_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            dir_q     <= dir_nxt;
            len_q     <= len_nxt;
            count_q   <= count_nxt;
            data_q    <= data_nxt;
            aborted_q <= aborted_nxt;
            rot_q     <= rot_nxt;
        end
    end

    // Next-state logic and Moore output decode, with abort forcing hold in SHIFT.
    always_comb begin
        state_nxt     = state;
        dir_nxt       = dir_q;
        len_nxt       = len_q;
        count_nxt     = count_q;
        data_nxt      = data_q;
        aborted_nxt   = aborted_q;
        rot_nxt       = rot_q;
        cmd.cmd_ready = 1'b0;
        s             = MODE_HOLD;
        p_in          = '0;
        s_r_in        = 1'b0;
        s_l_in        = 1'b0;
        ser_out       = 1'b0;
        ser_out_valid = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        aborted       = 1'b0;
        result        = '0;

        case (state)
            ST_IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    dir_nxt     = cmd.cmd_dir;
                    len_nxt     = cmd.cmd_len;
                    data_nxt    = cmd.cmd_data;
                    rot_nxt     = rot_in;
                    aborted_nxt = 1'b0;
                    count_nxt   = '0;
                    state_nxt   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy      = 1'b1;
                s         = MODE_LOAD;
                p_in      = data_q;
                count_nxt = LEN_W'(1);
                state_nxt = (len_q != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                busy    = 1'b1;
                ser_out = departing;
                if (abort) begin
                    aborted_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                end else begin
                    s             = dir_q ? MODE_LEFT : MODE_RIGHT;
                    ser_out_valid = 1'b1;
                    if (dir_q) begin
                        s_l_in = fill;
                    end else begin
                        s_r_in = fill;
                    end
                    // count compares against len before incrementing, so len=max never wraps
                    if (count_q == len_q) begin
                        state_nxt = ST_DONE;
                    end else begin
                        count_nxt = count_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                busy      = 1'b1;
                done      = 1'b1;
                aborted   = aborted_q;
                result    = q_fb;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Directed bench for usr_shift_ctrl with a behavioural 4-bit USR closing the loop.
module tb_usr_shift_ctrl;
    localparam int unsigned W = 4;
    localparam int unsigned L = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ser_in;
    logic         abort;
    logic [W-1:0] q_fb;
    logic [1:0]   s;
    logic [W-1:0] p_in;
    logic         s_r_in;
    logic         s_l_in;
    logic         ser_out;
    logic         ser_out_valid;
    logic         busy;
    logic         done;
    logic         aborted;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    usr_shift_ctrl_if #(.WIDTH(W), .LEN_W(L)) cmd_if ();

    usr_shift_ctrl #(.WIDTH(W), .LEN_W(L)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd           (cmd_if),
        .ser_in        (ser_in),
        .abort         (abort),
        .q_fb          (q_fb),
        .s             (s),
        .p_in          (p_in),
        .s_r_in        (s_r_in),
        .s_l_in        (s_l_in),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .result        (result)
    );

    always #5 clk = ~clk;

    // Behavioural universal shift register attached downstream.
    always @(posedge clk) begin
        if (rst) q_fb <= '0;
        else begin
            case (s)
                2'b11:   q_fb <= p_in;
                2'b01:   q_fb <= {s_r_in, q_fb[W-1:1]};
                2'b10:   q_fb <= {q_fb[W-2:0], s_l_in};
                default: q_fb <= q_fb;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic dir, input logic [L-1:0] len, input logic [W-1:0] data,
                        input logic rot);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_len   = len;
        cmd_if.cmd_data  = data;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
        cmd_if.cmd_rot   = rot;
`else
        if (rot) $display("note: rotate requested without rotate build");
`endif
    endtask

    initial begin
        logic [3:0] exp_bits;
        int sov_cnt;
        int done_at;
        rst = 1'b1; ser_in = 1'b0; abort = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_dir = 1'b0;
        cmd_if.cmd_len = '0; cmd_if.cmd_data = '0;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
        cmd_if.cmd_rot = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s", 8'(s), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_done", 8'(done), 8'h0);
        chk("rst_sov", 8'(ser_out_valid), 8'h0);
        chk("rst_pin", 8'(p_in), 8'h0);
        chk("rst_ready", 8'(cmd_if.cmd_ready), 8'h1);
        rst = 1'b0;

        // right shift of 1011 by 4 with zero fill
        @(negedge clk); send(1'b0, 4'd4, 4'b1011, 1'b0); ser_in = 1'b0; #1;
        chk("t1_ready", 8'(cmd_if.cmd_ready), 8'h1);
        @(negedge clk); cmd_if.cmd_valid = 1'b0; #1;
        chk("t1_load_s", 8'(s), 8'h3);
        chk("t1_load_pin", 8'(p_in), 8'hb);
        chk("t1_load_busy", 8'(busy), 8'h1);
        chk("t1_load_ready", 8'(cmd_if.cmd_ready), 8'h0);
        exp_bits = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("t1_shift_s", 8'(s), 8'h1);
            chk("t1_ser_out", 8'(ser_out), 8'(exp_bits[i]));
            chk("t1_sov", 8'(ser_out_valid), 8'h1);
            chk("t1_pin_zero", 8'(p_in), 8'h0);
        end
        @(negedge clk); #1;
        chk("t1_done", 8'(done), 8'h1);
        chk("t1_result", 8'(result), 8'h0);
        chk("t1_aborted", 8'(aborted), 8'h0);
        chk("t1_done_s", 8'(s), 8'h0);
        chk("t1_done_sov", 8'(ser_out_valid), 8'h0);
        @(negedge clk); #1;
        chk("t1_idle_done", 8'(done), 8'h0);
        chk("t1_idle_ready", 8'(cmd_if.cmd_ready), 8'h1);

        // left shift of 0110 by 2 with one fill
        @(negedge clk); send(1'b1, 4'd2, 4'b0110, 1'b0); ser_in = 1'b1; #1;
        @(negedge clk); cmd_if.cmd_valid = 1'b0; #1;
        chk("t2_load_s", 8'(s), 8'h3);
        exp_bits = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("t2_shift_s", 8'(s), 8'h2);
            chk("t2_ser_out", 8'(ser_out), 8'(exp_bits[i]));
            chk("t2_sl_in", 8'(s_l_in), 8'h1);
            chk("t2_sr_in", 8'(s_r_in), 8'h0);
        end
        @(negedge clk); #1;
        chk("t2_done", 8'(done), 8'h1);
        chk("t2_result", 8'(result), 8'hb);

        // load only, cmd_valid held through DONE
        @(negedge clk); send(1'b0, 4'd0, 4'b1001, 1'b0); #1;
        @(negedge clk); #1;
        chk("t3_load_s", 8'(s), 8'h3);
        chk("t3_load_sov", 8'(ser_out_valid), 8'h0);
        @(negedge clk); #1;
        chk("t3_done", 8'(done), 8'h1);
        chk("t3_result", 8'(result), 8'h9);
        chk("t3_done_ready", 8'(cmd_if.cmd_ready), 8'h0);
        @(negedge clk); #1;
        chk("t3_idle_ready", 8'(cmd_if.cmd_ready), 8'h1);
        chk("t3_idle_s", 8'(s), 8'h0);
        @(negedge clk); cmd_if.cmd_valid = 1'b0; #1;
        chk("t3_reaccept_s", 8'(s), 8'h3);
        @(negedge clk); #1;
        chk("t3_redone", 8'(done), 8'h1);
        @(negedge clk); #1;

        // abort on second shift cycle
        @(negedge clk); send(1'b0, 4'd4, 4'b1111, 1'b0); ser_in = 1'b0; #1;
        @(negedge clk); cmd_if.cmd_valid = 1'b0; #1;
        @(negedge clk); #1;
        chk("t4_shift1_s", 8'(s), 8'h1);
        @(negedge clk); abort = 1'b1; #1;
        chk("t4_abort_s", 8'(s), 8'h0);
        chk("t4_abort_sov", 8'(ser_out_valid), 8'h0);
        @(negedge clk); abort = 1'b0; #1;
        chk("t4_done", 8'(done), 8'h1);
        chk("t4_aborted", 8'(aborted), 8'h1);
        chk("t4_result", 8'(result), 8'h7);
        @(negedge clk); #1;

        // reset during a long shift sequence
        @(negedge clk); send(1'b0, 4'd8, 4'b1010, 1'b0); ser_in = 1'b1; #1;
        @(negedge clk); cmd_if.cmd_valid = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); rst = 1'b1; #1;
        @(negedge clk); rst = 1'b0; #1;
        chk("t5_rst_s", 8'(s), 8'h0);
        chk("t5_rst_busy", 8'(busy), 8'h0);
        chk("t5_rst_ready", 8'(cmd_if.cmd_ready), 8'h1);
        chk("t5_rst_done", 8'(done), 8'h0);
        @(negedge clk); send(1'b1, 4'd1, 4'b0011, 1'b0); ser_in = 1'b0; #1;
        @(negedge clk); cmd_if.cmd_valid = 1'b0; #1;
        chk("t5_load_s", 8'(s), 8'h3);
        @(negedge clk); #1;
        chk("t5_ser_out", 8'(ser_out), 8'h0);
        @(negedge clk); #1;
        chk("t5_done", 8'(done), 8'h1);
        chk("t5_result", 8'(result), 8'h6);
        chk("t5_aborted", 8'(aborted), 8'h0);
        @(negedge clk); #1;

        // maximum length: 15 shifts, no early wrap of the counter
        @(negedge clk); send(1'b0, 4'd15, 4'b1000, 1'b0); ser_in = 1'b1; #1;
        sov_cnt = 0; done_at = -1;
        for (int i = 1; i <= 40 && done_at < 0; i++) begin
            @(negedge clk); cmd_if.cmd_valid = 1'b0; #1;
            if (ser_out_valid) sov_cnt++;
            if (done) begin
                done_at = i;
                chk("t6_result", 8'(result), 8'hf);
            end
        end
        chk("t6_sov_cycles", 8'(sov_cnt), 8'd15);
        chk("t6_done_at", 8'(done_at), 8'd17);
        @(negedge clk); #1;

`ifdef USR_SHIFT_CTRL_ROTATE_EN
        // rotate right by a full width restores the value
        @(negedge clk); send(1'b0, 4'd4, 4'b1000, 1'b1); ser_in = 1'b1; #1;
        @(negedge clk); cmd_if.cmd_valid = 1'b0; #1;
        exp_bits = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("t7_ser_out", 8'(ser_out), 8'(exp_bits[i]));
        end
        @(negedge clk); #1;
        chk("t7_done", 8'(done), 8'h1);
        chk("t7_result", 8'(result), 8'h8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/usr_shift_ctrl.md
Name: usr_shift_ctrl

Overview:
- Command sequencer sitting directly upstream of the 4-bit universal shift register (USR).
- Accepts one command over a valid/ready handshake, then drives the USR mode select, parallel data and serial fill inputs cycle by cycle: parallel-load, then N shifts left or right.
- Reads the USR outputs back and presents the departing bit as a serial stream.
- Signals completion with a one-cycle done pulse carrying the final register value.

Parameters:
- WIDTH, 4, register width; must equal the attached USR width.
- LEN_W, 4, width of the shift-count field; maximum shift count is 2^LEN_W-1.

Ports:
- clk  input  1  rising-edge clock, shared with the USR.
- rst  input  1  synchronous active-high reset; also wired to the USR rst.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_dir  input  1  0 = shift right (toward bit 0), 1 = shift left (toward bit WIDTH-1).
- cmd_len  input  LEN_W  number of shifts after the load; 0 = load only.
- cmd_data  input  WIDTH  parallel value to load.
- ser_in  input  1  live serial fill bit, entering the vacated end each shift.
- abort  input  1  stop the shift sequence early.
- q_fb  input  WIDTH  USR q output, fed back.
- s  output  2  USR mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- p_in  output  WIDTH  USR parallel input.
- s_r_in  output  1  USR right-shift serial input (enters bit WIDTH-1).
- s_l_in  output  1  USR left-shift serial input (enters bit 0).
- ser_out  output  1  bit leaving the USR this cycle.
- ser_out_valid  output  1  ser_out qualifier.
- busy  output  1  high in LOAD, SHIFT and DONE.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  valid with done; 1 if the sequence ended via abort.
- result  output  WIDTH  equals q_fb while done=1.

Behaviour:
- FSM states: IDLE, LOAD, SHIFT, DONE. Outputs are Moore decodes of registered state, except the abort override noted below.
- Reset: state=IDLE, s=00, p_in=0, s_r_in=0, s_l_in=0, ser_out=0, ser_out_valid=0, busy=0, done=0, aborted=0. Internal dir, len, count and data registers cleared.
- Reset mid-operation: sequence abandoned with no done pulse. USR holds from the next cycle; cmd_ready=1 the cycle after the reset edge.
- IDLE: cmd_ready=1, s=00. On cmd_valid&cmd_ready, capture dir/len/data and go to LOAD. Commands are never accepted outside IDLE.
- LOAD (1 cycle): s=11, p_in=captured data. Go to SHIFT if len!=0, else DONE. p_in=0 in all other states.
- SHIFT (len cycles, count runs 1..len):
  - s=01 if dir=0, 10 if dir=1.
  - Right shift: s_r_in=fill, s_l_in=0, ser_out=q_fb[0].
  - Left shift: s_l_in=fill, s_r_in=0, ser_out=q_fb[WIDTH-1].
  - fill=ser_in.
  - ser_out_valid=1.
  - After the len-th cycle go to DONE.
- Abort in SHIFT: s forced to 00 that same cycle (combinational override), ser_out_valid=0, no shift occurs. Next state DONE with aborted=1. abort is ignored in IDLE, LOAD and DONE.
- DONE (1 cycle): done=1, result=q_fb (final register value), s=00. Then IDLE.
- Latency: accept edge to done = len+2 cycles; minimum command spacing = len+3 cycles.
- Max len (2^LEN_W-1) is legal. Shifting past WIDTH simply continues to clock in fill bits. The count counter must not wrap early.

Optional Feature:
- Macro USR_SHIFT_CTRL_ROTATE_EN.
- When defined: adds input port cmd_rot (1 bit), captured at accept. If captured cmd_rot=1, fill = the departing bit (q_fb[0] for right, q_fb[WIDTH-1] for left) and ser_in is ignored, so WIDTH shifts restore the original value.
- When undefined: cmd_rot port absent; fill is always ser_in.

Test Plan:
- Reset, then cmd data=1011, dir=0, len=4, ser_in=0 -> s sequence 11,01,01,01,01,00. ser_out=1,1,0,1 with valid high 4 cycles. done 6 cycles after accept, result=0000, aborted=0.
- data=0110, dir=1, len=2, ser_in=1 -> ser_out=0,1. done at accept+4, result=1011.
- data=1001, len=0 -> s=11 one cycle, no ser_out_valid. done at accept+2, result=1001. cmd_valid held high in DONE must not be accepted until IDLE.
- data=1111, dir=0, len=4, ser_in=0, abort on 2nd SHIFT cycle -> s=00 that cycle, only one shift performed. done next cycle with aborted=1, result=0111.
- rst asserted during SHIFT of a len=8 command -> next cycle s=00, busy=0, cmd_ready=1, no done pulse. A new command then completes normally.
- (USR_SHIFT_CTRL_ROTATE_EN) data=1000, dir=0, len=4, cmd_rot=1, ser_in=1 -> ser_out=0,0,0,1; result=1000.
